// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the mux serializer: FSM state encoding and select-width helpers.
package mux_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Select width for a W:1 mux; a 1-bit select is the minimum even for W=2.
  function automatic int sw_of(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic mux4(input logic [3:0] d, input logic [1:0] sel);
    return d[sel];
  endfunction

endpackage

// File: rtl/mux_wx1.sv
// W:1 bit-select mux (y = i[s]); the 8-bit case is two 4:1 stages feeding a 2:1 stage.
module mux_wx1
  import mux_serializer_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = sw_of(W)
) (
  input  logic [W-1:0]  i,
  input  logic [SW-1:0] s,
  output logic          y
);

  generate
    if (W == 8) begin : g_tree8
      logic lo;
      logic hi;
      always_comb begin
        lo = mux4(i[3:0], s[1:0]);
        hi = mux4(i[7:4], s[1:0]);
        y  = s[2] ? hi : lo;
      end
    end else begin : g_flat
      always_comb begin
        y = i[s];
      end
    end
  endgenerate

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage: holds one W-bit word and steps a mux select to emit one bit per beat.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int SW       = sw_of(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  i,
  output logic          y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] s,
  output logic          first,
  output logic          last,
  output logic          busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Input: word accepted when in_valid & in_ready. Output: bit consumed when
  // out_valid & out_ready. in_ready may depend on out_ready, never on in_valid.

  localparam logic [SW-1:0] START_IDX = MSB_FIRST ? SW'(W - 1) : '0;
  localparam logic [SW-1:0] END_IDX   = MSB_FIRST ? '0 : SW'(W - 1);

  state_t        state_q;
  logic [W-1:0]  word_q;
  logic [SW-1:0] s_q;
  logic          mux_bit;
  logic          shifting;
  logic          at_last;
  logic          beat;

  mux_wx1 #(.W(W), .SW(SW)) u_mux (
    .i (word_q),
    .s (s_q),
    .y (mux_bit)
  );

  always_comb begin
    shifting  = (state_q == SHIFT);
    at_last   = shifting && (s_q == END_IDX);
    beat      = shifting && out_ready;
    in_ready  = !shifting || (at_last && out_ready);
    out_valid = shifting;
    busy      = shifting;
    y         = shifting && mux_bit;
    first     = shifting && (s_q == START_IDX);
    last      = at_last;
    s         = s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      s_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q  <= i;
            s_q     <= START_IDX;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (at_last) begin
              // Reload on the final beat keeps the stream gap-free.
              if (in_valid) begin
                word_q <= i;
                s_q    <= START_IDX;
              end else begin
                s_q     <= '0;
                state_q <= IDLE;
              end
            end else if (MSB_FIRST) begin
              s_q <= s_q - SW'(1);
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: LSB-first and MSB-first instances sharing clock and reset.
module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, y, out_valid, out_ready, first, last, busy;
  logic [7:0] i;
  logic [2:0] s;

  logic       m_in_valid, m_in_ready, m_y, m_out_valid, m_out_ready, m_first, m_last, m_busy;
  logic [7:0] m_i;
  logic [2:0] m_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_serializer #(.W(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i(i),
    .y(y), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .first(first), .last(last), .busy(busy)
  );

  mux_serializer #(.W(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .i(m_i),
    .y(m_y), .out_valid(m_out_valid), .out_ready(m_out_ready), .s(m_s),
    .first(m_first), .last(m_last), .busy(m_busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] w, input int b, input logic exp_rdy);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(y), 32'(w[b]));
    chk({tag, "_s"}, 32'(s), 32'(b));
    chk({tag, "_first"}, 32'(first), 32'(b == 0));
    chk({tag, "_last"}, 32'(last), 32'(b == 7));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
  endtask

  logic [7:0] w;

  initial begin
    rst = 1'b1; in_valid = 1'b1; i = 8'hFF; out_ready = 1'b1;
    m_in_valid = 1'b0; m_i = 8'h00; m_out_ready = 1'b1;

    // 1 reset held with in_valid high
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle("reset");
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_s", 32'(s), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk_idle("post_reset_no_load");
    chk("post_reset_first", 32'(first), 32'd0);
    chk("post_reset_last", 32'(last), 32'd0);

    // 2 single word A5, LSB first
    w = 8'hA5; i = w; in_valid = 1'b1;
    #1;
    chk("single_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; i = 8'h00;
    #1;
    for (int b = 0; b < 8; b++) begin
      chk_beat("single", w, b, b == 7);
      tick();
    end
    chk_idle("single_done");

    // 3 back-to-back 0F then F0
    i = 8'h0F; in_valid = 1'b1;
    tick();
    i = 8'hF0;
    #1;
    for (int b = 0; b < 16; b++) begin
      if (b == 8) begin
        in_valid = 1'b0;
        #1;
      end
      w = (b < 8) ? 8'h0F : 8'hF0;
      chk_beat("b2b", w, b % 8, (b % 8) == 7);
      tick();
    end
    chk_idle("b2b_done");

    // 4 backpressure at beat 3 of 3C
    w = 8'h3C; i = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_y", 32'(y), 32'(w[3]));
          chk("stall_s", 32'(s), 32'd3);
          chk("stall_last", 32'(last), 32'd0);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          tick();
        end
        out_ready = 1'b1;
        #1;
      end
      chk_beat("bp", w, b, b == 7);
      tick();
    end
    chk_idle("bp_done");

    // 5 reset at beat 4, then 81
    w = 8'h5A; i = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk_beat("pre_rst", w, b, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    tick();
    chk_idle("mid_rst_hold");
    w = 8'h81; i = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    for (int b = 0; b < 8; b++) begin
      chk_beat("after_rst", w, b, b == 7);
      tick();
    end
    chk_idle("after_rst_done");

    // 6 MSB first, word 01
    m_i = 8'h01; m_in_valid = 1'b1;
    #1;
    chk("msb_accept_ready", 32'(m_in_ready), 32'd1);
    tick();
    m_in_valid = 1'b0;
    #1;
    for (int b = 0; b < 8; b++) begin
      chk("msb_out_valid", 32'(m_out_valid), 32'd1);
      chk("msb_y", 32'(m_y), 32'(b == 7));
      chk("msb_s", 32'(m_s), 32'(7 - b));
      chk("msb_first", 32'(m_first), 32'(b == 0));
      chk("msb_last", 32'(m_last), 32'(b == 7));
      tick();
    end
    chk("msb_done_out_valid", 32'(m_out_valid), 32'd0);
    chk("msb_done_busy", 32'(m_busy), 32'd0);
    chk("msb_done_in_ready", 32'(m_in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
